// File: rtl/montgomery_exp_ctrl_if.sv
// montgomery_exp_ctrl_if
//   Bundles the host-side command/status signals and the multiplier-side
//   request/response signals of the Montgomery exponentiation sequencer.
//
//   Host side:       start_p, base_mont, one_mont, exponent, ebits  (to ctrl)
//                    busy, result, done_irq_p, op_count             (from ctrl)
//   Multiplier side: mul_enable_p, mul_a, mul_b                     (from ctrl)
//                    mul_y, mul_done_p                              (to ctrl)
//
//   slave  : view used by the sequencer itself.
//   master : view used by the environment (host plus attached multiplier).
`timescale 1ns/1ps
interface montgomery_exp_ctrl_if #(
    parameter int NBITS = 256,
    parameter int EBITS = 256
);
    localparam int EW = $clog2(EBITS) + 1;

    logic             start_p;
    logic [NBITS-1:0] base_mont;
    logic [NBITS-1:0] one_mont;
    logic [EBITS-1:0] exponent;
    logic [EW-1:0]    ebits;
    logic             busy;
    logic [NBITS-1:0] result;
    logic             done_irq_p;
    logic [15:0]      op_count;
    logic             mul_enable_p;
    logic [NBITS-1:0] mul_a;
    logic [NBITS-1:0] mul_b;
    logic [NBITS-1:0] mul_y;
    logic             mul_done_p;

    modport slave (
        input  start_p, base_mont, one_mont, exponent, ebits, mul_y, mul_done_p,
        output busy, result, done_irq_p, op_count, mul_enable_p, mul_a, mul_b
    );

    modport master (
        output start_p, base_mont, one_mont, exponent, ebits, mul_y, mul_done_p,
        input  busy, result, done_irq_p, op_count, mul_enable_p, mul_a, mul_b
    );
endinterface

// File: rtl/montgomery_exp_ctrl.sv
// montgomery_exp_ctrl
//   Left-to-right square-and-multiply modular exponentiation sequencer that
//   drives one Montgomery multiplier. All values stay in Montgomery form.
//
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : montgomery_exp_ctrl_if.slave
//          host in : start_p, base_mont, one_mont, exponent, ebits
//          host out: busy, result, done_irq_p, op_count
//          mult out: mul_enable_p, mul_a, mul_b
//          mult in : mul_y, mul_done_p
`timescale 1ns/1ps
module montgomery_exp_ctrl #(
    parameter int NBITS = 256,
    parameter int EBITS = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    montgomery_exp_ctrl_if.slave bus
);
    localparam int IDXW = $clog2(EBITS) + 1;
    localparam int BITW = (EBITS > 1) ? $clog2(EBITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SQR_REQ,
        SQR_WAIT,
        MUL_REQ,
        MUL_WAIT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             mul_enable;
    logic             done_irq;
    logic [NBITS-1:0] acc;
    logic [NBITS-1:0] base_r;
    logic [EBITS-1:0] exp_r;
    logic [IDXW-1:0]  idx;
    logic [15:0]      op_count_r;
    logic [NBITS-1:0] result_r;
    logic [NBITS-1:0] mul_a_r;
    logic [NBITS-1:0] mul_b_r;
    logic             cur_bit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // idx has already been decremented in CHECK, so it points at the bit
    // whose square is in flight.
    assign cur_bit = exp_r[idx[BITW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        mul_enable = 1'b0;
        done_irq   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_p) begin
                    state_n = CHECK;
                end
            end
            CHECK: begin
                state_n = (idx == '0) ? DONE : SQR_REQ;
            end
            SQR_REQ: begin
                mul_enable = 1'b1;
                state_n    = SQR_WAIT;
            end
            SQR_WAIT: begin
                if (bus.mul_done_p) begin
                    state_n = cur_bit ? MUL_REQ : CHECK;
                end
            end
            MUL_REQ: begin
                mul_enable = 1'b1;
                state_n    = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (bus.mul_done_p) begin
                    state_n = CHECK;
                end
            end
            DONE: begin
                done_irq = 1'b1;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            base_r     <= '0;
            exp_r      <= '0;
            idx        <= '0;
            op_count_r <= '0;
            result_r   <= '0;
            mul_a_r    <= '0;
            mul_b_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_p) begin
                        base_r     <= bus.base_mont;
                        exp_r      <= bus.exponent;
                        acc        <= bus.one_mont;
                        idx        <= (bus.ebits > IDXW'(EBITS)) ? IDXW'(EBITS) : bus.ebits;
                        op_count_r <= '0;
                    end
                end
                CHECK: begin
                    // Result is captured on the way into DONE so it is already
                    // valid during the done_irq_p cycle.
                    if (idx == '0) begin
                        result_r <= acc;
                    end else begin
                        idx     <= idx - IDXW'(1);
                        mul_a_r <= acc;
                        mul_b_r <= acc;
                    end
                end
                SQR_REQ, MUL_REQ: begin
                    op_count_r <= sat_inc(op_count_r);
                end
                SQR_WAIT: begin
                    if (bus.mul_done_p) begin
                        acc <= bus.mul_y;
                        // Operands for the multiply step come straight from the
                        // square result, since acc only updates on this edge.
                        if (cur_bit) begin
                            mul_a_r <= bus.mul_y;
                            mul_b_r <= base_r;
                        end
                    end
                end
                MUL_WAIT: begin
                    if (bus.mul_done_p) begin
                        acc <= bus.mul_y;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.done_irq_p   = done_irq;
    assign bus.mul_enable_p = mul_enable;
    assign bus.result       = result_r;
    assign bus.op_count     = op_count_r;
    assign bus.mul_a        = mul_a_r;
    assign bus.mul_b        = mul_b_r;
endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
`timescale 1ns/1ps
module tb_montgomery_exp_ctrl;
    localparam int NB = 32;
    localparam int EB = 16;
    localparam int EW = $clog2(EB) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    montgomery_exp_ctrl_if #(.NBITS(NB), .EBITS(EB)) bus();

    montgomery_exp_ctrl #(.NBITS(NB), .EBITS(EB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // multiplier model controls
    longint unsigned mod_m     = 7;
    int              lat_fixed = 3;
    bit              inject_en = 1'b0;
    bit              orphan    = 1'b0;
    int              mul_cnt   = 0;
    logic [NB-1:0]   op_a_q[$];
    logic [NB-1:0]   op_b_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Multiplier model: y = a*b mod mod_m, done L cycles after the enable cycle.
    initial begin : mul_model
        int            cnt;
        logic [NB-1:0] ca;
        logic [NB-1:0] cb;
        bit            stable;
        cnt    = 0;
        ca     = '0;
        cb     = '0;
        stable = 1'b1;
        bus.mul_done_p = 1'b0;
        bus.mul_y      = '0;
        forever begin
            tick();
            bus.mul_done_p = 1'b0;
            if (cnt > 0) begin
                if (bus.mul_a !== ca || bus.mul_b !== cb) stable = 1'b0;
                cnt--;
                if (cnt == 0) begin
                    bus.mul_done_p = 1'b1;
                    bus.mul_y      = NB'((longint'(ca) * longint'(cb)) % mod_m);
                    if (!orphan) begin
                        checks++;
                        if (!stable) begin
                            errors++;
                            $display("FAIL operand_hold: a/b changed during wait (a=0x%0h b=0x%0h)", ca, cb);
                        end
                    end
                    orphan = 1'b0;
                end
            end
            if (bus.mul_enable_p === 1'b1) begin
                ca     = bus.mul_a;
                cb     = bus.mul_b;
                stable = 1'b1;
                cnt    = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 10));
                mul_cnt++;
                op_a_q.push_back(ca);
                op_b_q.push_back(cb);
                if (inject_en && $urandom_range(0, 1) == 1) begin
                    bus.mul_done_p = 1'b1;
                    bus.mul_y      = NB'($urandom);
                end
            end else if (inject_en && bus.busy === 1'b0 && $urandom_range(0, 3) == 0) begin
                bus.mul_done_p = 1'b1;
                bus.mul_y      = NB'($urandom);
            end
        end
    end

    // Reference: left-to-right processing of n bits starting from one gives
    // one^(2^n) * base^e (mod m), with n squarings plus popcount(e) multiplies.
    function automatic longint unsigned powmod(longint unsigned b, longint unsigned e, longint unsigned m);
        longint unsigned r;
        r = 1 % m;
        b = b % m;
        while (e > 0) begin
            if (e[0]) r = (r * b) % m;
            b = (b * b) % m;
            e = e >> 1;
        end
        return r;
    endfunction

    task automatic reference(input logic [NB-1:0] base, input logic [NB-1:0] one, input logic [EB-1:0] e,
                             input int eb, output logic [NB-1:0] res, output logic [15:0] ops);
        int              n;
        longint unsigned sq;
        longint unsigned em;
        n  = (eb > EB) ? EB : eb;
        em = (n == 0) ? 0 : (longint'(e) & ((64'd1 << n) - 1));
        if (n == 0) begin
            res = one;
        end else begin
            sq = one;
            for (int i = 0; i < n; i++) sq = (sq * sq) % mod_m;
            res = NB'((sq * powmod(base, em, mod_m)) % mod_m);
        end
        ops = 16'(n + $countones(em));
    endtask

    task automatic run(input logic [NB-1:0] base, input logic [NB-1:0] one, input logic [EB-1:0] e,
                       input logic [EW-1:0] eb, input int mid_start,
                       output logic [NB-1:0] res, output logic [15:0] ops, output int cycles,
                       output int busy_cyc, output int extra_done, output bit timeout);
        int n;
        op_a_q.delete();
        op_b_q.delete();
        mul_cnt       = 0;
        bus.base_mont = base;
        bus.one_mont  = one;
        bus.exponent  = e;
        bus.ebits     = eb;
        bus.start_p   = 1'b1;
        busy_cyc      = 0;
        extra_done    = 0;
        timeout       = 1'b0;
        res           = '0;
        ops           = '0;
        tick();
        bus.start_p = 1'b0;
        n = 2;
        forever begin
            if (bus.busy === 1'b1) busy_cyc++;
            if (bus.done_irq_p === 1'b1) break;
            if (n > 5000) begin
                timeout = 1'b1;
                break;
            end
            if (n == mid_start) bus.start_p = 1'b1;
            tick();
            bus.start_p = 1'b0;
            n++;
        end
        cycles = n;
        res    = bus.result;
        ops    = bus.op_count;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done_irq_p === 1'b1) extra_done++;
        end
    endtask

    typedef struct {
        logic [NB-1:0]   base;
        logic [NB-1:0]   one;
        logic [EB-1:0]   e;
        logic [EW-1:0]   eb;
        int              lat;
        int              mid;
        logic [NB-1:0]   x_res;
        logic [15:0]     x_ops;
        int              x_cyc;
        int              x_busy;
    } vec_t;

    vec_t vecs[7];

    initial begin : main
        logic [NB-1:0] res;
        logic [15:0]   ops;
        int            cyc;
        int            bcyc;
        int            xdone;
        bit            to;
        int            seq_a[5];
        int            seq_b[5];
        int            en_seen;
        logic [NB-1:0] rres;
        logic [15:0]   rops;
        int            reb;

        vecs[0] = '{32'd3, 32'd1,      16'd5,      5'd3,  3, -1, 32'd5,      16'd5,  26, 25};
        vecs[1] = '{32'd3, 32'h1234,   16'd5,      5'd0,  3, -1, 32'h1234,   16'd0,  3,  2};
        vecs[2] = '{32'd3, 32'd1,      16'd5,      5'd3,  1, -1, 32'd5,      16'd5,  16, 15};
        vecs[3] = '{32'd2, 32'd1,      16'h00FF,   5'd8,  3, 20, 32'd1,      16'd16, 75, 74};
        vecs[4] = '{32'd3, 32'd1,      16'hFFFF,   5'd17, 1, -1, 32'd6,      16'd32, 83, 82};
        vecs[5] = '{32'd3, 32'd1,      16'hF0F5,   5'd3,  2, -1, 32'd5,      16'd5,  21, 20};
        vecs[6] = '{32'd1, 32'd2,      16'h0000,   5'd2,  2, -1, 32'd2,      16'd2,  11, 10};
        seq_a = '{1, 1, 3, 2, 4};
        seq_b = '{1, 3, 3, 2, 3};

        bus.start_p   = 1'b0;
        bus.base_mont = '0;
        bus.one_mont  = '0;
        bus.exponent  = '0;
        bus.ebits     = '0;

        // reset state
        #1;
        check("rst_busy",   bus.busy,         1'b0);
        check("rst_done",   bus.done_irq_p,   1'b0);
        check("rst_result", bus.result,       '0);
        check("rst_ops",    bus.op_count,     '0);
        check("rst_en",     bus.mul_enable_p, 1'b0);
        check("rst_a",      bus.mul_a,        '0);
        check("rst_b",      bus.mul_b,        '0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // table-driven vectors, mod-7 model
        for (int v = 0; v < 7; v++) begin
            lat_fixed = vecs[v].lat;
            run(vecs[v].base, vecs[v].one, vecs[v].e, vecs[v].eb, vecs[v].mid, res, ops, cyc, bcyc, xdone, to);
            check($sformatf("v%0d_timeout", v), 64'(to), 64'd0);
            check($sformatf("v%0d_result", v), res, vecs[v].x_res);
            check($sformatf("v%0d_ops", v), ops, vecs[v].x_ops);
            check($sformatf("v%0d_enables", v), 64'(mul_cnt), 64'(vecs[v].x_ops));
            check($sformatf("v%0d_cycles", v), 64'(cyc), 64'(vecs[v].x_cyc));
            check($sformatf("v%0d_busy_cycles", v), 64'(bcyc), 64'(vecs[v].x_busy));
            check($sformatf("v%0d_extra_done", v), 64'(xdone), 64'd0);
            check($sformatf("v%0d_busy_after", v), bus.busy, 1'b0);
            if (v == 0) begin
                for (int i = 0; i < 5; i++) begin
                    check($sformatf("v0_op%0d_a", i), (i < op_a_q.size()) ? op_a_q[i] : 'x, NB'(seq_a[i]));
                    check($sformatf("v0_op%0d_b", i), (i < op_b_q.size()) ? op_b_q[i] : 'x, NB'(seq_b[i]));
                end
            end
        end

        // start_p coinciding with done_irq_p is ignored; accepted when held a cycle longer
        lat_fixed     = 3;
        bus.one_mont  = 32'h55;
        bus.ebits     = '0;
        bus.start_p   = 1'b1;
        tick();
        bus.start_p = 1'b0;
        tick();
        check("sd_done_cycle", bus.done_irq_p, 1'b1);
        bus.start_p = 1'b1;
        tick();
        check("sd_ignored_busy", bus.busy, 1'b0);
        check("sd_ignored_done", bus.done_irq_p, 1'b0);
        tick();
        bus.start_p = 1'b0;
        check("sd_accept_busy", bus.busy, 1'b1);
        tick();
        check("sd_second_done", bus.done_irq_p, 1'b1);
        check("sd_second_result", bus.result, 32'h55);
        tick();

        // reset during the second squaring wait, late multiplier completion
        lat_fixed     = 3;
        bus.base_mont = 32'd3;
        bus.one_mont  = 32'd1;
        bus.exponent  = 16'd5;
        bus.ebits     = 5'd3;
        bus.start_p   = 1'b1;
        tick();
        bus.start_p = 1'b0;
        en_seen = 0;
        for (int i = 0; i < 200 && en_seen < 3; i++) begin
            tick();
            if (bus.mul_enable_p === 1'b1) en_seen++;
        end
        check("rr_reached_sqr2", 64'(en_seen), 64'd3);
        tick();
        orphan = 1'b1;
        rst    = 1'b1;
        #1;
        check("rr_busy",   bus.busy,       1'b0);
        check("rr_result", bus.result,     '0);
        check("rr_ops",    bus.op_count,   '0);
        check("rr_a",      bus.mul_a,      '0);
        check("rr_b",      bus.mul_b,      '0);
        tick();
        rst = 1'b0;
        xdone = 0;
        bcyc  = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done_irq_p === 1'b1) xdone++;
            if (bus.busy === 1'b1) bcyc++;
        end
        check("rr_no_done",  64'(xdone), 64'd0);
        check("rr_idle",     64'(bcyc),  64'd0);
        check("rr_ops_zero", bus.op_count, '0);
        check("rr_res_zero", bus.result,   '0);
        run(32'd3, 32'd1, 16'd5, 5'd3, -1, res, ops, cyc, bcyc, xdone, to);
        check("rr_rerun_result", res, 32'd5);
        check("rr_rerun_ops", ops, 16'd5);

        // randomized runs: random latency, spurious completions
        mod_m     = 1000003;
        lat_fixed = 0;
        inject_en = 1'b1;
        for (int r = 0; r < 20; r++) begin
            logic [NB-1:0] b;
            logic [NB-1:0] o;
            logic [EB-1:0] e;
            b   = NB'($urandom_range(0, 1000002));
            o   = NB'($urandom_range(0, 1000002));
            e   = EB'($urandom);
            reb = $urandom_range(0, EB + 1);
            reference(b, o, e, reb, rres, rops);
            run(b, o, e, EW'(reb), $urandom_range(2, 40), res, ops, cyc, bcyc, xdone, to);
            check($sformatf("r%0d_timeout", r), 64'(to), 64'd0);
            check($sformatf("r%0d_result", r), res, rres);
            check($sformatf("r%0d_ops", r), ops, rops);
            check($sformatf("r%0d_extra_done", r), 64'(xdone), 64'd0);
        end
        inject_en = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/montgomery_exp_ctrl.md
Name: montgomery_exp_ctrl

Overview:
- Initiator-side sequencer for the Montgomery multiplier core. It drives the multiplier's enable_p / a / b inputs and consumes its y / done_irq_p outputs.
- Computes a left-to-right binary (square-and-multiply) modular exponentiation entirely in the Montgomery domain.
- Sits between the crypto top level and one instance of the multiplier. It replaces the bench-style operand sequencing with hardware.
- Operands arrive pre-converted to the Montgomery domain. Conversion in and out stays outside this block.

Parameters:
- NBITS, 256, operand/modulus width; must match the attached multiplier's NBITS.
- EBITS, 256, maximum exponent width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start_p  input  1  one-cycle start pulse.
- base_mont  input  NBITS  base in Montgomery form (x·R mod m).
- one_mont  input  NBITS  R mod m, initial accumulator value.
- exponent  input  EBITS  exponent bits.
- ebits  input  $clog2(EBITS)+1  number of exponent bits to process, MSB-first from bit ebits-1.
- busy  output  1  high from accepted start until done_irq_p.
- result  output  NBITS  final accumulator, Montgomery form.
- done_irq_p  output  1  one-cycle completion pulse.
- op_count  output  16  multiplier requests issued in the current/last run.
- mul_enable_p  output  1  one-cycle request to the multiplier.
- mul_a  output  NBITS  multiplier operand A.
- mul_b  output  NBITS  multiplier operand B.
- mul_y  input  NBITS  multiplier result.
- mul_done_p  input  1  multiplier completion pulse.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal acc, base, exp and idx registers 0. Reset is asynchronous and can be asserted mid-run; the FSM returns to IDLE at once.
- Late multiplier completion: a mul_done_p arriving after reset is ignored.
- Start accept:
  - In IDLE, start_p sampled high latches base_mont, exponent, acc<=one_mont, idx<=min(ebits,EBITS), op_count<=0, busy<=1.
  - start_p while busy is ignored, with no effect on any state.
- States: IDLE, CHECK, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, DONE.
- CHECK (cycle after accept, or after each bit):
  - idx==0 -> DONE.
  - Otherwise idx<=idx-1 -> SQR_REQ.
- SQR_REQ: mul_enable_p=1 for exactly one cycle, mul_a=mul_b=acc, op_count+1 -> SQR_WAIT.
- SQR_WAIT: on mul_done_p, acc<=mul_y. Then exp[idx]==1 -> MUL_REQ, else -> CHECK.
- MUL_REQ: mul_enable_p=1 for one cycle, mul_a=acc, mul_b=base, op_count+1 -> MUL_WAIT.
- MUL_WAIT: on mul_done_p, acc<=mul_y -> CHECK.
- mul_a/mul_b hold their values from the REQ cycle until the matching mul_done_p.
- DONE: result<=acc, done_irq_p=1 for one cycle, busy<=0 -> IDLE. result holds until the next DONE or reset.
- mul_done_p sampled outside the WAIT states is ignored.
- mul_done_p in the same cycle as the REQ state is not accepted; the multiplier has latency ≥1.
- Latency: with multiplier latency L (enable to done), total = 2 + Σ over processed bits (1 + L + 1 + [bit]·(L+1)) + 1 cycles from start_p to done_irq_p.
- ebits==0: no multiplier request; result=one_mont; done_irq_p exactly 3 cycles after start_p (accept, CHECK, DONE).
- ebits>EBITS: clamped to EBITS.
- start_p in the same cycle as done_irq_p: ignored (FSM is in DONE, not IDLE). It is accepted the following cycle if reasserted.
- op_count saturates at 16'hFFFF.

Test Plan:
- Bench multiplier model y=(a·b) mod 7, latency 3, one_mont=1; base_mont=3, exponent=5, ebits=3 -> result=5 (3^5 mod 7); op_count=5; exactly 5 mul_enable_p pulses in order S,M,S,S,M.
- ebits=0, one_mont=0x1234 -> no mul_enable_p; result=0x1234; done_irq_p 3 cycles after start_p; busy high 2 cycles.
- exponent=0xFF, ebits=8, base=2, mod-7 model -> result=2^255 mod 7=1; op_count=16. A second start_p pulsed mid-run is ignored: op_count stays 16 and there is a single done_irq_p.
- Assert rst during the 2nd SQR_WAIT, then the model issues mul_done_p -> outputs all 0, state IDLE, no done_irq_p. A fresh run afterwards (base=3, exp=5, ebits=3) gives result=5.
- Spurious mul_done_p injected in IDLE and MUL_REQ cycles, model latency varied 1..10 randomly -> results identical to the reference run; mul_a/mul_b stable during every wait.
- ebits=EBITS+1 with exponent all ones -> behaves as ebits=EBITS; op_count=2·EBITS.
